timer1_peripheral: RTL and testbench
====================================

Name: timer1_peripheral

Overview:
- 16-bit Timer1 peripheral on the core's external peripheral register bus, downstream of the midrange core.
- Decodes the core's peripheral address/data outputs and returns read data to the core's peripheral data input.
- Counts instruction-cycle ticks or external T1CKI rising edges through a 1/2/4/8 prescaler.
- Raises a one-cycle strobe on the core's PIR1 interrupt strobe bus (bit 0, TMR1IF) on overflow.

Parameters:
- TMR1L_ADDR, 9'h00E, absolute register-file address of TMR1L.
- TMR1H_ADDR, 9'h00F, absolute register-file address of TMR1H.
- T1CON_ADDR, 9'h010, absolute register-file address of T1CON.

Ports:
- clk  in  1  system clock. One clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- addr  in  9  register-file address from the core.
- data_in  in  8  write data from the core (ALU output).
- wr_en  in  1  register-file write strobe from the core, qualified with addr.
- data_out  out  8  read data to the core. Combinational on addr; 8'h00 when addr does not hit this block.
- tick  in  1  one-clk pulse per instruction cycle (clk/4 enable).
- t1cki  in  1  external clock pin, asynchronous.
- tmr1if_strobe  out  1  one-clk overflow pulse, wired to PIR1 strobe bit 0.

Behaviour:
- Reset (asynchronous, immediate), including mid-count:
  - TMR1 = 16'h0000, T1CON = 8'h00, prescaler = 0.
  - Synchroniser flops = 0, edge-history flop = 0.
  - tmr1if_strobe = 0.
- T1CON fields:
  - [7:6] read as 0, writes ignored.
  - [5:4] T1CKPS: 00 = /1, 01 = /2, 10 = /4, 11 = /8.
  - [3:2] stored and read back, no function.
  - [1] TMR1CS: 0 = tick source, 1 = external edge source.
  - [0] TMR1ON.
- Reads:
  - data_out = TMR1[7:0], TMR1[15:8] or {2'b00, T1CON[5:0]} for the matching address.
  - Reads are side-effect free.
- Writes: when wr_en is high and addr matches, the addressed register loads data_in at the clock edge.
  - Any write to TMR1L, TMR1H or T1CON clears the prescaler.
- External path:
  - t1cki passes through a 2-flop synchroniser (s1, s2), then a history flop (s3).
  - ext_edge = s2 & ~s3.
  - The counter sees the edge on the 3rd rising clk after t1cki rises.
  - Synchroniser and history flops run regardless of TMR1ON.
- Source event: src = TMR1CS ? ext_edge : tick, gated by TMR1ON.
  - With TMR1ON = 0, the prescaler and TMR1 hold.
- Prescaler: 3-bit counter.
  - On src, if prescaler == divisor-1: clear the prescaler and increment TMR1.
  - Otherwise prescaler + 1.
  - With /1, every src increments TMR1.
- Increment: TMR1 + 1 modulo 2^16; takes effect on the same edge as the qualifying src.
- Overflow: an increment from 16'hFFFF to 16'h0000 sets tmr1if_strobe = 1 for exactly the following clk cycle (registered alongside the counter).
  - No other condition asserts it. Writing 16'hFFFF then 0 does not strobe.
- Simultaneous write and increment: the write wins.
  - The written byte loads, the other byte holds, and the increment that cycle is dropped.
  - The prescaler clears; no overflow strobe.
- A T1CON write that changes TMR1CS or T1CKPS takes effect from the next cycle; the prescaler is cleared.
- No 16-bit read/write buffering: TMR1L and TMR1H are accessed independently.

Test Plan:
- Reset and read-back:
  - Assert rst mid-count with T1CON = 8'h31, TMR1 = 16'h1234.
  - Required: every register reads 0x00 immediately and tmr1if_strobe = 0.
  - Then write T1CON = 8'hFF. Required: read 0x3F.
- Internal /1 overflow:
  - Write TMR1H = 0xFF, TMR1L = 0xFE, T1CON = 0x01; pulse tick every 4 clk.
  - Required: TMR1 reads 0xFFFF after the 1st tick and 0x0000 after the 2nd.
  - tmr1if_strobe is high for exactly one clk right after the 2nd wrap edge.
- Prescaler /8:
  - T1CON = 0x31, TMR1 = 0, 24 ticks. Required: TMR1 = 3.
  - Write TMR1L = 0 after 5 ticks. Required: the next increment arrives 8 ticks after the write.
- External source:
  - T1CON = 0x03, tick held low, 5 t1cki pulses (each high ≥ 3 clk).
  - Required: TMR1 = 5, and each increment occurs on the 3rd clk after the t1cki rise.
- Write/increment collision:
  - T1CON = 0x01, TMR1 = 0x00FF; write TMR1L = 0x10 on the same edge as a tick.
  - Required: TMR1 = 0x0010, no strobe.
- Disable and hold:
  - Clear TMR1ON at TMR1 = 0x0042 and apply 10 ticks. Required: TMR1 stays 0x0042.
  - Unrelated addr 9'h020 reads 0x00.

Source files
------------

// File: rtl/timer1_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module      : timer1_peripheral_if
// Description : Peripheral register bus between the midrange core (master)
//               and the Timer1 block (slave): address, write data, write
//               strobe and combinational read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface timer1_peripheral_if;
    logic [8:0] addr;
    logic [7:0] data_in;
    logic       wr_en;
    logic [7:0] data_out;

    // Core side drives address/data/strobe and receives read data
    modport master (
        output addr,
        output data_in,
        output wr_en,
        input  data_out
    );

    // Peripheral side decodes the bus and returns read data
    modport slave (
        input  addr,
        input  data_in,
        input  wr_en,
        output data_out
    );
endinterface
`default_nettype wire

// File: rtl/timer1_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : timer1_peripheral
// Description : 16-bit Timer1 on the core's peripheral register bus. Counts
//               instruction-cycle ticks or synchronised T1CKI rising edges
//               through a 1/2/4/8 prescaler and pulses TMR1IF on overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module timer1_peripheral #(
    parameter logic [8:0] TMR1L_ADDR = 9'h00E,
    parameter logic [8:0] TMR1H_ADDR = 9'h00F,
    parameter logic [8:0] T1CON_ADDR = 9'h010
) (
    input  wire logic              clk,
    input  wire logic              rst,
    timer1_peripheral_if.slave     bus,
    input  wire logic              tick,
    input  wire logic              t1cki,
    output logic                   tmr1if_strobe
);

    // T1CON bit positions; bits 7:6 are not stored and read as zero
    localparam int C_TMR1ON_BIT = 0;
    localparam int C_TMR1CS_BIT = 1;
    localparam int C_CKPS_LSB   = 4;

    // Registered state
    logic [15:0] tmr1_q,    tmr1_d;
    logic [5:0]  t1con_q,   t1con_d;
    logic [2:0]  presc_q,   presc_d;
    logic        sync1_q,   sync1_d;
    logic        sync2_q,   sync2_d;
    logic        hist_q,    hist_d;
    logic        strobe_q,  strobe_d;

    // Decode / datapath wires
    logic        w_hit_l;
    logic        w_hit_h;
    logic        w_hit_con;
    logic        w_any_wr;
    logic        w_ext_edge;
    logic        w_src;
    logic [2:0]  w_div_max;
    logic [1:0]  w_ckps;

    // Bus write decode, event source selection and prescaler terminal count
    always_comb begin
        w_hit_l    = bus.wr_en && (bus.addr == TMR1L_ADDR);
        w_hit_h    = bus.wr_en && (bus.addr == TMR1H_ADDR);
        w_hit_con  = bus.wr_en && (bus.addr == T1CON_ADDR);
        w_any_wr   = w_hit_l || w_hit_h || w_hit_con;
        // Rising edge seen after the two-flop synchroniser
        w_ext_edge = sync2_q & ~hist_q;
        w_src      = t1con_q[C_TMR1ON_BIT] &
                     (t1con_q[C_TMR1CS_BIT] ? w_ext_edge : tick);
        w_ckps     = t1con_q[C_CKPS_LSB +: 2];
        case (w_ckps)
            2'b00:   w_div_max = 3'd0;
            2'b01:   w_div_max = 3'd1;
            2'b10:   w_div_max = 3'd3;
            default: w_div_max = 3'd7;
        endcase
    end

    // Next-state: a bus write always wins over a count event in the same cycle
    always_comb begin
        tmr1_d   = tmr1_q;
        t1con_d  = t1con_q;
        presc_d  = presc_q;
        strobe_d = 1'b0;
        sync1_d  = t1cki;
        sync2_d  = sync1_q;
        hist_d   = sync2_q;

        if (w_any_wr) begin
            // Any register access restarts the prescale sequence; the
            // increment that would have happened this cycle is dropped.
            presc_d = 3'd0;
            if (w_hit_l) begin
                tmr1_d[7:0] = bus.data_in;
            end
            if (w_hit_h) begin
                tmr1_d[15:8] = bus.data_in;
            end
            if (w_hit_con) begin
                t1con_d = bus.data_in[5:0];
            end
        end else if (w_src) begin
            if (presc_q == w_div_max) begin
                presc_d  = 3'd0;
                tmr1_d   = tmr1_q + 16'd1;
                // Only a genuine count-through-wrap raises the flag
                strobe_d = (tmr1_q == 16'hFFFF);
            end else begin
                presc_d = presc_q + 3'd1;
            end
        end
    end

    // State register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr1_q   <= 16'h0000;
            t1con_q  <= 6'h00;
            presc_q  <= 3'd0;
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            hist_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            tmr1_q   <= tmr1_d;
            t1con_q  <= t1con_d;
            presc_q  <= presc_d;
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            hist_q   <= hist_d;
            strobe_q <= strobe_d;
        end
    end

    // Side-effect-free combinational read mux; unmapped addresses read zero
    always_comb begin
        bus.data_out = 8'h00;
        if (bus.addr == TMR1L_ADDR) begin
            bus.data_out = tmr1_q[7:0];
        end else if (bus.addr == TMR1H_ADDR) begin
            bus.data_out = tmr1_q[15:8];
        end else if (bus.addr == T1CON_ADDR) begin
            bus.data_out = {2'b00, t1con_q};
        end
    end

    assign tmr1if_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_timer1_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : tb_timer1_peripheral
// Description : Directed self-checking bench for timer1_peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_timer1_peripheral;

    localparam logic [8:0] C_L   = 9'h00E;
    localparam logic [8:0] C_H   = 9'h00F;
    localparam logic [8:0] C_CON = 9'h010;

    logic clk;
    logic rst;
    logic tick;
    logic t1cki;
    logic tmr1if_strobe;

    int          vectors;
    int          miscompares;
    logic [15:0] strobe_cnt;
    logic [15:0] cnt_snap;
    logic [15:0] v16;
    logic [7:0]  v8;

    timer1_peripheral_if bus_if ();

    timer1_peripheral dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus_if),
        .tick          (tick),
        .t1cki         (t1cki),
        .tmr1if_strobe (tmr1if_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count strobe cycles, sampled 1 time unit after each rising edge
    initial strobe_cnt = 16'd0;
    always @(posedge clk) begin
        #1;
        if (tmr1if_strobe === 1'b1) strobe_cnt = strobe_cnt + 16'd1;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [8:0] a, input logic [7:0] d);
        @(negedge clk);
        bus_if.addr    = a;
        bus_if.data_in = d;
        bus_if.wr_en   = 1'b1;
        @(negedge clk);
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic rd8(input logic [8:0] a, output logic [7:0] v);
        bus_if.addr = a;
        #1;
        v = bus_if.data_out;
    endtask

    task automatic rd16(output logic [15:0] v);
        logic [7:0] lo;
        logic [7:0] hi;
        rd8(C_L, lo);
        rd8(C_H, hi);
        v = {hi, lo};
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        rst            = 1'b1;
        tick           = 1'b0;
        t1cki          = 1'b0;
        bus_if.addr    = 9'h000;
        bus_if.data_in = 8'h00;
        bus_if.wr_en   = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Reset mid-count
        wr(C_L, 8'h34);
        wr(C_H, 8'h12);
        wr(C_CON, 8'h31);
        ticks(3);
        rd16(v16);
        chk("pre_reset_tmr1", v16, 16'h1234);
        @(negedge clk);
        #1 rst = 1'b1;
        rd8(C_L, v8);   chk("reset_tmr1l", {8'd0, v8}, 16'h0000);
        rd8(C_H, v8);   chk("reset_tmr1h", {8'd0, v8}, 16'h0000);
        rd8(C_CON, v8); chk("reset_t1con", {8'd0, v8}, 16'h0000);
        chk("reset_strobe", {15'd0, tmr1if_strobe}, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        wr(C_CON, 8'hFF);
        rd8(C_CON, v8); chk("t1con_readback", {8'd0, v8}, 16'h003F);
        wr(C_CON, 8'h00);

        // Internal /1 overflow
        wr(C_H, 8'hFF);
        wr(C_L, 8'hFE);
        wr(C_CON, 8'h01);
        cnt_snap = strobe_cnt;
        ticks(1);
        rd16(v16);
        chk("ovf_tick1", v16, 16'hFFFF);
        chk("ovf_no_early_strobe", strobe_cnt, cnt_snap);
        @(negedge clk);
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        chk("ovf_strobe_high", {15'd0, tmr1if_strobe}, 16'h0001);
        rd16(v16);
        chk("ovf_tick2_wrap", v16, 16'h0000);
        @(negedge clk);
        chk("ovf_strobe_low", {15'd0, tmr1if_strobe}, 16'h0000);
        repeat (3) @(negedge clk);
        chk("ovf_strobe_count", strobe_cnt, cnt_snap + 16'd1);

        // Writing FFFF then 0 must not strobe
        wr(C_CON, 8'h00);
        cnt_snap = strobe_cnt;
        wr(C_L, 8'hFF);
        wr(C_H, 8'hFF);
        wr(C_L, 8'h00);
        wr(C_H, 8'h00);
        @(negedge clk);
        chk("write_wrap_no_strobe", strobe_cnt, cnt_snap);

        // Prescaler /8
        wr(C_CON, 8'h31);
        ticks(24);
        rd16(v16); chk("div8_24_ticks", v16, 16'h0003);
        ticks(5);
        rd16(v16); chk("div8_5_more", v16, 16'h0003);
        wr(C_L, 8'h00);
        ticks(7);
        rd16(v16); chk("div8_7_after_wr", v16, 16'h0000);
        ticks(1);
        rd16(v16); chk("div8_8_after_wr", v16, 16'h0001);

        // External source, tick held low
        wr(C_CON, 8'h00);
        wr(C_L, 8'h00);
        wr(C_H, 8'h00);
        wr(C_CON, 8'h03);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            t1cki = 1'b1;
            @(negedge clk);
            @(negedge clk);
            rd16(v16); chk("ext_after_2nd_clk", v16, 16'(k));
            @(negedge clk);
            rd16(v16); chk("ext_after_3rd_clk", v16, 16'(k + 1));
            @(negedge clk);
            t1cki = 1'b0;
            repeat (3) @(negedge clk);
        end
        rd16(v16); chk("ext_total", v16, 16'h0005);

        // Write/increment collision
        wr(C_CON, 8'h00);
        wr(C_L, 8'hFF);
        wr(C_H, 8'h00);
        wr(C_CON, 8'h01);
        cnt_snap = strobe_cnt;
        @(negedge clk);
        tick           = 1'b1;
        bus_if.addr    = C_L;
        bus_if.data_in = 8'h10;
        bus_if.wr_en   = 1'b1;
        @(negedge clk);
        tick         = 1'b0;
        bus_if.wr_en = 1'b0;
        rd16(v16); chk("collision_value", v16, 16'h0010);
        repeat (2) @(negedge clk);
        chk("collision_no_strobe", strobe_cnt, cnt_snap);

        // Disable and hold
        ticks(50);
        rd16(v16); chk("count_to_42", v16, 16'h0042);
        wr(C_CON, 8'h00);
        ticks(10);
        rd16(v16); chk("disabled_hold", v16, 16'h0042);
        rd8(9'h020, v8); chk("unmapped_read", {8'd0, v8}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
